tape_prefetch: RTL and testbench
================================

Name: tape_prefetch

Overview:
- Byte-fetch stage directly upstream of the CPC tape player.
- Serves the player's level request (`rd`, `addr`) from two 8-byte line buffers and answers each request with `din` plus a one-cycle `rd_en` pulse.
- Refills the line buffers from the tape image in SDRAM over a 64-bit line-read port, and optionally prefetches the next line so playback never stalls on memory latency.

Parameters:
- ADDR_W, 25, byte address width of the tape image (matches tape_size/addr).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- flush  in  1  one-cycle pulse on new image load; invalidates both lines.
- rd  in  1  player byte request, level; high until answered.
- addr  in  ADDR_W  requested byte address, stable while rd high.
- rd_en  out  1  one-cycle strobe; din valid in the same cycle.
- din  out  8  returned byte.
- mem_rd  out  1  line read request, level; held until mem_ack.
- mem_addr  out  ADDR_W  line address, bits [2:0] always 0.
- mem_ack  in  1  one-cycle pulse; mem_data valid in that cycle.
- mem_data  in  64  line data; byte n = bits [8n+7:8n].

Behaviour:
- Reset values: rd_en=0, din=0, mem_rd=0, mem_addr=0, both valid=0, lru=0, both FSMs idle. Reset is honoured mid-fetch; a late mem_ack is ignored.
- Each line holds: tag = addr[ADDR_W-1:3], valid bit, 64-bit data.
- Hit test: valid && tag == addr[ADDR_W-1:3].
- Request FSM states: IDLE, LOOKUP, WAIT_MEM, DONE.
  - IDLE: rd=1 -> LOOKUP.
  - LOOKUP, on hit: register din = byte addr[2:0]; pulse rd_en in the next cycle; go to DONE. On a hit, lru points to the other line.
  - LOOKUP, on miss: go to WAIT_MEM and raise a demand fetch for line {addr[ADDR_W-1:3],3'b0}.
  - WAIT_MEM: when the line becomes valid -> respond as for a hit -> DONE.
  - DONE: rd_en low; wait for rd=0, then -> IDLE. A request is never answered twice.
  - rd falling in LOOKUP or WAIT_MEM: abort to IDLE with no rd_en; an in-flight fetch still completes into its line.
- Hit latency: rd rising at cycle 0 gives rd_en at cycle 2. Miss latency: rd_en 2 cycles after mem_ack.
- Memory FSM states: M_IDLE, M_BUSY.
  - Demand fetches have priority over prefetches.
  - Target line = lru, never the line currently being hit.
  - On issue: clear the target's valid bit and write its tag.
  - mem_ack: write data, set valid, -> M_IDLE.
  - mem_rd drops in the cycle after mem_ack. Exactly one fetch is outstanding at a time.
- Demand miss while a fetch is in flight:
  - If the in-flight tag equals the needed line, wait for it; no duplicate fetch.
  - Otherwise wait for completion, then issue the demand fetch.
- flush:
  - Clears both valid bits and lru in the same cycle.
  - An in-flight fetch finishes its handshake, but its data is discarded (valid stays 0).
  - A pending request re-evaluates as a miss.
  - flush coinciding with mem_ack: flush wins.
- Address arithmetic is unsigned and ADDR_W wide. The next-line address for the top line wraps to 0, but prefetch is suppressed there.

Optional Feature:
- Macro: TAPE_PREFETCH_EN.
- Defined:
  - After any hit on line L, if the memory FSM is idle, L is not the top line, and the other line does not hold or await L+1, fetch L+1 into the other line.
  - Sequential playback then sees only hit latency after the first line.
- Undefined: fetches occur on demand misses only; prefetch logic is absent.

Decomposition:
- Package tape_pkg:
  - LINE_BYTES=8, LINE_SH=3.
  - Enums req_state_t {IDLE,LOOKUP,WAIT_MEM,DONE} and mem_state_t {M_IDLE,M_BUSY}.
  - typedef line_t {valid, tag, data}.
- One sub-module, tape_line_buf: two line entries, tag compare, byte select, write port. Both FSMs stay in tape_prefetch.

Test Plan:
- Cold miss: flush, rd with addr=0x000005, mem_ack after 10 cycles with mem_data=0x0706050403020100 -> mem_addr=0 while mem_rd high; din=0x05, rd_en pulse 2 cycles after ack; no second rd_en while rd stays high.
- Sequential hits: addr 0x06 then 0x07 after the cold miss -> each answered 2 cycles after rd rise; mem_rd stays low (without TAPE_PREFETCH_EN).
- Prefetch (TAPE_PREFETCH_EN): hit at 0x06 -> mem_rd with mem_addr=0x000008; a later request at 0x08 hits with 2-cycle latency and no further fetch.
- Flush mid-fetch: flush during M_BUSY, then mem_ack -> line stays invalid; the following rd at the same addr issues a new fetch.
- Top line: hit at 0x1FFFFFF with prefetch enabled -> no prefetch issued, mem_addr never wraps to 0.
- Abort: rd drops during WAIT_MEM -> no rd_en; the fetch completes; a later rd at the same addr hits in 2 cycles.

Source files
------------

// File: rtl/tape_pkg.sv
// Shared types and constants for the tape byte-fetch stage.
package tape_pkg;

  localparam int LINE_BYTES  = 8;
  localparam int LINE_SH     = 3;
  localparam int TAPE_ADDR_W = 25;
  localparam int TAG_W       = TAPE_ADDR_W - LINE_SH;

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_MEM, DONE} req_state_t;
  typedef enum logic {M_IDLE, M_BUSY} mem_state_t;

  typedef struct packed {
    logic                      valid;
    logic [TAG_W-1:0]          tag;
    logic [8*LINE_BYTES-1:0]   data;
  } line_t;

endpackage

// File: rtl/tape_prefetch_if.sv
// 64-bit line-read port between the fetch stage (master) and SDRAM (slave).
interface tape_prefetch_if #(parameter int ADDR_W = 25);

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [63:0]       mem_data;

  modport master (output mem_rd, mem_addr, input mem_ack, mem_data);
  modport slave  (input mem_rd, mem_addr, output mem_ack, mem_data);

endinterface

// File: rtl/tape_line_buf.sv
// Two 8-byte line entries: tag compare, byte select, tag/valid update on
// fetch issue and data write on fetch completion. Line data is not reset;
// only valid and tag are. Extra "other line" outputs exist only when
// TAPE_PREFETCH_EN is defined.
module tape_line_buf
  import tape_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [ADDR_W-LINE_SH-1:0]  look_tag,
  input  logic [LINE_SH-1:0]         look_off,
  output logic                       hit,
  output logic                       hit_idx,
  output logic [7:0]                 hit_byte,
`ifdef TAPE_PREFETCH_EN
  output logic                       other_valid,
  output logic [TAG_W-1:0]           other_tag,
`endif
  input  logic                       issue,
  input  logic                       issue_idx,
  input  logic [ADDR_W-LINE_SH-1:0]  issue_tag,
  input  logic                       fill,
  input  logic                       fill_idx,
  input  logic                       fill_valid,
  input  logic [63:0]                fill_data
);

  localparam int TW = ADDR_W - LINE_SH;

  logic [1:0]    valid_q;
  logic [TW-1:0] tag_q  [2];
  logic [63:0]   data_q [2];
  line_t         lines  [2];
  logic          hit0;
  logic          hit1;

  // Valid/tag: issue invalidates and retags, fill validates, flush clears all
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
    end else begin
      if (issue) begin
        valid_q[issue_idx] <= 1'b0;
        tag_q[issue_idx]   <= issue_tag;
      end
      if (fill) begin
        valid_q[fill_idx] <= fill_valid;
      end
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  // Line data written on every completed fetch, even a discarded one
  always_ff @(posedge clk_sys) begin
    if (fill) begin
      data_q[fill_idx] <= fill_data;
    end
  end

  // Lookup: hit test against both lines and byte select from the hit line
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lines[i] = '{valid: valid_q[i], tag: TAG_W'(tag_q[i]), data: data_q[i]};
    end
    hit0     = lines[0].valid && (lines[0].tag == TAG_W'(look_tag));
    hit1     = lines[1].valid && (lines[1].tag == TAG_W'(look_tag));
    hit      = hit0 || hit1;
    hit_idx  = !hit0;
    hit_byte = lines[hit_idx].data[{look_off, 3'b000} +: 8];
`ifdef TAPE_PREFETCH_EN
    other_valid = lines[~hit_idx].valid;
    other_tag   = lines[~hit_idx].tag;
`endif
  end

endmodule

// File: rtl/tape_prefetch.sv
// Byte-fetch stage for the tape player: answers byte requests from two line
// buffers and refills them over a 64-bit line-read port. Defining
// TAPE_PREFETCH_EN adds next-line prefetch after every hit.
module tape_prefetch
  import tape_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               rd,
  input  logic [ADDR_W-1:0]  addr,
  output logic               rd_en,
  output logic [7:0]         din,
  tape_prefetch_if.master    mem
);

  localparam int TW = ADDR_W - LINE_SH;

  req_state_t    req_q, req_d;
  mem_state_t    mem_q, mem_d;
  logic          lru_q;
  logic          fetch_idx_q;
  logic [TW-1:0] fetch_tag_q;
  logic          discard_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [TW-1:0] look_tag;
  logic          hit, hit_idx, hit_eff;
  logic [7:0]    hit_byte;
  logic          active, respond, inflight_match, demand;
  logic          pf_go;
  logic [TW-1:0] pf_tag;
  logic          issue, issue_idx, fill, fill_valid;
  logic [TW-1:0] issue_tag;

  assign look_tag = addr[ADDR_W-1:LINE_SH];

`ifdef TAPE_PREFETCH_EN
  logic             other_valid;
  logic [TAG_W-1:0] other_tag;
  logic [TW-1:0]    next_tag;
`endif

  tape_line_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .flush      (flush),
    .look_tag   (look_tag),
    .look_off   (addr[LINE_SH-1:0]),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_byte   (hit_byte),
`ifdef TAPE_PREFETCH_EN
    .other_valid(other_valid),
    .other_tag  (other_tag),
`endif
    .issue      (issue),
    .issue_idx  (issue_idx),
    .issue_tag  (issue_tag),
    .fill       (fill),
    .fill_idx   (fetch_idx_q),
    .fill_valid (fill_valid),
    .fill_data  (mem.mem_data)
  );

  // A flush in the same cycle forces the pending request to re-evaluate as a miss
  assign hit_eff        = hit && !flush;
  assign active         = ((req_q == LOOKUP) || (req_q == WAIT_MEM)) && rd;
  assign respond        = active && hit_eff;
  assign inflight_match = (mem_q == M_BUSY) && !discard_q && (fetch_tag_q == look_tag);
  assign demand         = active && !hit_eff && !inflight_match;

`ifdef TAPE_PREFETCH_EN
  // Next line goes into the line not being hit; top line never wraps to 0
  assign next_tag = look_tag + TW'(1);
  assign pf_tag   = next_tag;
  assign pf_go    = respond && (mem_q == M_IDLE) && !(&look_tag) &&
                    !(other_valid && (other_tag == TAG_W'(next_tag)));
`else
  assign pf_tag   = look_tag;
  assign pf_go    = 1'b0;
`endif

  // Request FSM next state
  always_comb begin
    req_d = req_q;
    case (req_q)
      IDLE:     if (rd) req_d = LOOKUP;
      LOOKUP:   if (!rd) req_d = IDLE;
                else if (hit_eff) req_d = DONE;
                else req_d = WAIT_MEM;
      WAIT_MEM: if (!rd) req_d = IDLE;
                else if (hit_eff) req_d = DONE;
      DONE:     if (!rd) req_d = IDLE;
      default:  req_d = IDLE;
    endcase
  end

  // Memory FSM next state: demand beats prefetch, one fetch outstanding
  always_comb begin
    mem_d      = mem_q;
    issue      = 1'b0;
    fill       = 1'b0;
    issue_idx  = demand ? lru_q : ~hit_idx;
    issue_tag  = demand ? look_tag : pf_tag;
    fill_valid = !flush && !discard_q;
    case (mem_q)
      M_IDLE: if (!flush && (demand || pf_go)) begin
                issue = 1'b1;
                mem_d = M_BUSY;
              end
      M_BUSY: if (mem.mem_ack) begin
                fill  = 1'b1;
                mem_d = M_IDLE;
              end
      default: mem_d = M_IDLE;
    endcase
  end

  // Request side state, response strobe/byte and replacement pointer
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= IDLE;
      rd_en <= 1'b0;
      din   <= '0;
      lru_q <= 1'b0;
    end else begin
      req_q <= req_d;
      rd_en <= respond;
      if (respond) din <= hit_byte;
      if (flush) lru_q <= 1'b0;
      else if (respond) lru_q <= ~hit_idx;
    end
  end

  // Memory side state: fetch bookkeeping and discard-on-flush marker
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_q       <= M_IDLE;
      mem_addr_q  <= '0;
      fetch_idx_q <= 1'b0;
      fetch_tag_q <= '0;
      discard_q   <= 1'b0;
    end else begin
      mem_q <= mem_d;
      if (issue) begin
        mem_addr_q  <= {issue_tag, {LINE_SH{1'b0}}};
        fetch_idx_q <= issue_idx;
        fetch_tag_q <= issue_tag;
        discard_q   <= 1'b0;
      end else if ((mem_q == M_BUSY) && flush) begin
        discard_q   <= 1'b1;
      end
    end
  end

  assign mem.mem_rd   = (mem_q == M_BUSY);
  assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_tape_prefetch.sv
// Directed bench for tape_prefetch: a table of byte requests with expected
// byte, latency class and fetch counts, plus hand sequences for flush during
// a fetch, request abort and reset during a fetch. Expectations differ where
// TAPE_PREFETCH_EN adds next-line fetches.
module tb_tape_prefetch;

  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          rd;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic [7:0]    din;

  tape_prefetch_if #(.ADDR_W(AW)) mif ();

  tape_prefetch #(.ADDR_W(AW)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .flush   (flush),
    .rd      (rd),
    .addr    (addr),
    .rd_en   (rd_en),
    .din     (din),
    .mem     (mif)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

  int            fetch_cnt    = 0;
  logic [AW-1:0] last_addr    = '0;
  int            last_ack_cyc = -100;
  int            ack_delay    = 10;
  bit            hold_ack     = 0;
  bit            force_ack    = 0;
  bit            busy_seen    = 0;
  int            wcnt         = 0;

  typedef struct {
    logic [AW-1:0] a;
    bit            miss;
    logic [7:0]    d;
    int            dr;
    int            de;
    logic [AW-1:0] last;
    int            pre;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Tape image model: byte at address a equals a[7:0]
  function automatic logic [63:0] line_of(input logic [AW-1:0] a);
    logic [63:0]   v;
    logic [AW-1:0] base;
    base = {a[AW-1:3], 3'b000};
    for (int n = 0; n < 8; n++) v[8*n +: 8] = 8'(base + AW'(n));
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk_sys); #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; cycle(); flush = 1'b0;
  endtask

  task automatic add(input logic [AW-1:0] a, input bit miss, input logic [7:0] d,
                     input int dr, input int de, input logic [AW-1:0] last, input int pre);
    vec_t v;
    v.a = a; v.miss = miss; v.d = d; v.dr = dr; v.de = de; v.last = last; v.pre = pre;
    tbl.push_back(v);
  endtask

  // SDRAM responder: acks each fetch ack_delay cycles after mem_rd is first seen
  initial begin
    mif.mem_ack  = 1'b0;
    mif.mem_data = '0;
    forever begin
      @(posedge clk_sys); #2;
      if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
        check("mem_rd_drop", 64'(mif.mem_rd), 0);
      end else if (force_ack) begin
        force_ack    = 0;
        mif.mem_ack  = 1'b1;
        mif.mem_data = line_of(addr);
      end else if (mif.mem_rd) begin
        if (!busy_seen) begin
          busy_seen = 1;
          wcnt      = 0;
          fetch_cnt++;
          last_addr = mif.mem_addr;
          check("mem_addr_align", 64'(mif.mem_addr[2:0]), 0);
        end else begin
          wcnt++;
        end
        if (!hold_ack && wcnt >= ack_delay) begin
          mif.mem_ack  = 1'b1;
          mif.mem_data = line_of(mif.mem_addr);
          busy_seen    = 0;
          last_ack_cyc = cyc_cnt;
        end
      end else begin
        busy_seen = 0;
      end
    end
  end

  task automatic do_req(input logic [AW-1:0] a, input bit miss, input logic [7:0] exp_din,
                        input int exp_dr, input int exp_de, input logic [AW-1:0] exp_last,
                        input string nm);
    int f0, start, extra;
    bit got;
    f0    = fetch_cnt;
    rd    = 1'b1;
    addr  = a;
    start = cyc_cnt;
    got   = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      cycle();
      if (rd_en) got = 1;
    end
    if (!got) begin
      check({nm, "_timeout"}, 0, 1);
    end else begin
      if (miss) check({nm, "_miss_lat"}, 64'(cyc_cnt - last_ack_cyc), 2);
      else      check({nm, "_hit_lat"}, 64'(cyc_cnt - start), 2);
      check({nm, "_din"}, 64'(din), 64'(exp_din));
      check({nm, "_fetch_at_resp"}, 64'(fetch_cnt - f0), 64'(exp_dr));
    end
    extra = 0;
    repeat (3) begin
      cycle();
      if (rd_en) extra++;
    end
    check({nm, "_once"}, 64'(extra), 0);
    rd = 1'b0;
    repeat (2) cycle();
    check({nm, "_fetch_total"}, 64'(fetch_cnt - f0), 64'(exp_de));
    if (exp_de > 0) check({nm, "_last_addr"}, 64'(last_addr), 64'(exp_last));
  endtask

  task automatic wait_mem_rd(input string nm);
    for (int i = 0; i < 20 && !mif.mem_rd; i++) cycle();
    check({nm, "_mem_rd"}, 64'(mif.mem_rd), 1);
  endtask

  initial begin
    int f0, cnt;
    bit got;
    reset_n = 1'b0; rd = 1'b0; flush = 1'b0; addr = '0;
    repeat (3) cycle();
    reset_n = 1'b1;
    cycle();
    check("rst_rd_en",    64'(rd_en), 0);
    check("rst_din",      64'(din), 0);
    check("rst_mem_rd",   64'(mif.mem_rd), 0);
    check("rst_mem_addr", 64'(mif.mem_addr), 0);

`ifdef TAPE_PREFETCH_EN
    add(25'h0000005, 1, 8'h05, 1, 2, 25'h0000008, 0);
    add(25'h0000006, 0, 8'h06, 0, 0, 25'h0000000, 0);
    add(25'h0000007, 0, 8'h07, 0, 0, 25'h0000000, 0);
    add(25'h0000008, 0, 8'h08, 0, 1, 25'h0000010, 0);
    add(25'h0000010, 0, 8'h10, 0, 1, 25'h0000018, 12);
    add(25'h1FFFFFF, 1, 8'hFF, 1, 1, 25'h1FFFFF8, 12);
    add(25'h1FFFFFE, 0, 8'hFE, 0, 0, 25'h0000000, 0);
`else
    add(25'h0000005, 1, 8'h05, 1, 1, 25'h0000000, 0);
    add(25'h0000006, 0, 8'h06, 0, 0, 25'h0000000, 0);
    add(25'h0000007, 0, 8'h07, 0, 0, 25'h0000000, 0);
    add(25'h0000008, 1, 8'h08, 1, 1, 25'h0000008, 0);
    add(25'h0000003, 0, 8'h03, 0, 0, 25'h0000000, 0);
    add(25'h0000010, 1, 8'h10, 1, 1, 25'h0000010, 0);
    add(25'h0000000, 0, 8'h00, 0, 0, 25'h0000000, 0);
    add(25'h000000A, 1, 8'h0A, 1, 1, 25'h0000008, 0);
    add(25'h1FFFFFF, 1, 8'hFF, 1, 1, 25'h1FFFFF8, 0);
    add(25'h1FFFFFE, 0, 8'hFE, 0, 0, 25'h0000000, 0);
`endif

    pulse_flush();
    cycle();
    foreach (tbl[i]) begin
      repeat (tbl[i].pre) cycle();
      do_req(tbl[i].a, tbl[i].miss, tbl[i].d, tbl[i].dr, tbl[i].de, tbl[i].last,
             $sformatf("vec%0d", i));
    end

    // Flush while a fetch is in flight: data discarded, request refetches
    repeat (15) cycle();
    pulse_flush();
    f0 = fetch_cnt;
    rd = 1'b1; addr = 25'h20;
    wait_mem_rd("flush_fetch");
    repeat (3) cycle();
    pulse_flush();
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      cycle();
      if (rd_en) got = 1;
    end
    check("flush_resp_seen", 64'(got), 1);
    check("flush_refetch",   64'(fetch_cnt - f0), 2);
    check("flush_lat",       64'(cyc_cnt - last_ack_cyc), 2);
    check("flush_din",       64'(din), 64'h20);
    rd = 1'b0;
    repeat (3) cycle();

    // Abort during WAIT_MEM: no answer, fetch still completes into its line
    repeat (15) cycle();
    pulse_flush();
    f0 = fetch_cnt;
    rd = 1'b1; addr = 25'h30;
    wait_mem_rd("abort");
    cycle();
    rd = 1'b0;
    cnt = 0;
    repeat (15) begin
      cycle();
      if (rd_en) cnt++;
    end
    check("abort_no_rd_en",  64'(cnt), 0);
    check("abort_fetch_cnt", 64'(fetch_cnt - f0), 1);
    check("abort_mem_idle",  64'(mif.mem_rd), 0);
`ifdef TAPE_PREFETCH_EN
    do_req(25'h30, 0, 8'h30, 0, 1, 25'h38, "abort_rehit");
`else
    do_req(25'h30, 0, 8'h30, 0, 0, 25'h00, "abort_rehit");
`endif

    // Reset during a fetch, then a late ack that must be ignored
    repeat (15) cycle();
    hold_ack = 1;
    rd = 1'b1; addr = 25'h40;
    wait_mem_rd("rst_mid");
    reset_n = 1'b0;
    cycle();
    check("rst_mid_rd_en",    64'(rd_en), 0);
    check("rst_mid_din",      64'(din), 0);
    check("rst_mid_mem_rd",   64'(mif.mem_rd), 0);
    check("rst_mid_mem_addr", 64'(mif.mem_addr), 0);
    rd = 1'b0;
    reset_n = 1'b1;
    cycle();
    hold_ack  = 0;
    force_ack = 1;
    repeat (3) cycle();
    check("late_ack_mem_rd", 64'(mif.mem_rd), 0);
    check("late_ack_rd_en",  64'(rd_en), 0);
`ifdef TAPE_PREFETCH_EN
    do_req(25'h40, 1, 8'h40, 1, 2, 25'h48, "post_rst");
`else
    do_req(25'h40, 1, 8'h40, 1, 1, 25'h40, "post_rst");
`endif

    repeat (15) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
